// File: rtl/load_unit.sv
// Load unit: issues one or two beat-aligned bus reads per load, merges the bytes
// and sign/zero-extends the result. Misaligned loads are split or flagged.
module load_unit #(
  parameter int XLEN           = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_data,
  output logic            o_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      funct3_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] beat0_reg, beat1_reg;
  logic [XLEN-1:0] data_reg;
  logic            err_reg;

  // Decode of the incoming request, only consumed on the accept edge
  logic       req_illegal, req_misalign, req_err;
  logic [3:0] req_size;

  always_comb begin
    req_illegal  = (i_funct3 == 3'b111) ||
                   ((XLEN == 32) && ((i_funct3 == 3'b011) || (i_funct3 == 3'b110)));
    req_size     = 4'd1 << i_funct3[1:0];
    req_misalign = (i_addr[3:0] & (req_size - 4'd1)) != 4'd0;
    req_err      = req_illegal || (req_misalign && (ALLOW_MISALIGN == 0));
  end

  logic [OFFW-1:0] offset;
  logic [3:0]      size_reg;
  logic            crosses;
  logic [XLEN-1:0] beat0_addr, beat1_addr;

  always_comb begin
    offset     = addr_reg[OFFW-1:0];
    size_reg   = 4'd1 << funct3_reg[1:0];
    crosses    = (5'(offset) + 5'(size_reg)) > 5'(NB);
    beat0_addr = {addr_reg[XLEN-1:OFFW], {OFFW{1'b0}}};
    beat1_addr = beat0_addr + XLEN'(NB);
  end

  // Merge uses the live bus data for whichever beat is arriving this cycle
  logic [XLEN-1:0]   merge_lo, merge_hi, word;
  logic [2*XLEN-1:0] pair;
  logic [OFFW+2:0]   shamt;
  logic [63:0]       w64, ext64;
  logic [XLEN-1:0]   data_next;

  always_comb begin
    merge_lo = (state_reg == RSP0) ? i_mem_rdata : beat0_reg;
    merge_hi = (state_reg == RSP1) ? i_mem_rdata : beat1_reg;
    pair     = {merge_hi, merge_lo};
    shamt    = {offset, 3'b000};
    word     = XLEN'(pair >> shamt);
    w64      = 64'(word);
    case (funct3_reg)
      3'b000:  ext64 = {{56{w64[7]}},  w64[7:0]};
      3'b001:  ext64 = {{48{w64[15]}}, w64[15:0]};
      3'b010:  ext64 = {{32{w64[31]}}, w64[31:0]};
      3'b100:  ext64 = {56'b0, w64[7:0]};
      3'b101:  ext64 = {48'b0, w64[15:0]};
      3'b110:  ext64 = {32'b0, w64[31:0]};
      default: ext64 = w64;
    endcase
    data_next = ext64[XLEN-1:0];
  end

  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_mem_req  = 1'b0;
    o_mem_addr = '0;
    o_valid    = 1'b0;
    o_data     = '0;
    o_err      = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = req_err ? DONE : REQ0;
      end
      REQ0: begin
        o_mem_req  = 1'b1;
        o_mem_addr = beat0_addr;
        if (i_mem_gnt) state_next = RSP0;
      end
      RSP0: begin
        if (i_mem_rvalid) state_next = crosses ? REQ1 : DONE;
      end
      REQ1: begin
        o_mem_req  = 1'b1;
        o_mem_addr = beat1_addr;
        if (i_mem_gnt) state_next = RSP1;
      end
      RSP1: begin
        if (i_mem_rvalid) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        o_data  = data_reg;
        o_err   = err_reg;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      funct3_reg <= '0;
      addr_reg   <= '0;
      beat0_reg  <= '0;
      beat1_reg  <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            funct3_reg <= i_funct3;
            addr_reg   <= i_addr;
            beat0_reg  <= '0;
            beat1_reg  <= '0;
            data_reg   <= '0;
            err_reg    <= req_err;
          end
        end
        RSP0: begin
          if (i_mem_rvalid) begin
            beat0_reg <= i_mem_rdata;
            if (!crosses) data_reg <= data_next;
          end
        end
        RSP1: begin
          if (i_mem_rvalid) begin
            beat1_reg <= i_mem_rdata;
            data_reg  <= data_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: three instances (32-bit split, 32-bit strict, 64-bit)
// share stimulus; only the selected instance sees i_valid.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid0, i_valid1, i_valid2;
  logic [2:0]  i_funct3;
  logic [63:0] i_addr;
  logic        i_mem_gnt, i_mem_rvalid, i_ready;
  logic [63:0] i_mem_rdata;

  logic        r0, mq0, v0, e0;
  logic [31:0] ma0, d0;
  logic        r1, mq1, v1, e1;
  logic [31:0] ma1, d1;
  logic        r2, mq2, v2, e2;
  logic [63:0] ma2, d2;

  int          sel;
  logic        cur_ready, cur_mem_req, cur_valid, cur_err;
  logic [63:0] cur_mem_addr, cur_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_unit #(.XLEN(32), .ALLOW_MISALIGN(1)) u_split32 (
    .clk(clk), .rst(rst), .i_valid(i_valid0), .o_ready(r0),
    .i_funct3(i_funct3), .i_addr(i_addr[31:0]),
    .o_mem_req(mq0), .o_mem_addr(ma0), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata[31:0]),
    .o_valid(v0), .i_ready(i_ready), .o_data(d0), .o_err(e0));

  load_unit #(.XLEN(32), .ALLOW_MISALIGN(0)) u_strict32 (
    .clk(clk), .rst(rst), .i_valid(i_valid1), .o_ready(r1),
    .i_funct3(i_funct3), .i_addr(i_addr[31:0]),
    .o_mem_req(mq1), .o_mem_addr(ma1), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata[31:0]),
    .o_valid(v1), .i_ready(i_ready), .o_data(d1), .o_err(e1));

  load_unit #(.XLEN(64), .ALLOW_MISALIGN(1)) u_split64 (
    .clk(clk), .rst(rst), .i_valid(i_valid2), .o_ready(r2),
    .i_funct3(i_funct3), .i_addr(i_addr),
    .o_mem_req(mq2), .o_mem_addr(ma2), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_valid(v2), .i_ready(i_ready), .o_data(d2), .o_err(e2));

  always_comb begin
    cur_ready = r2; cur_mem_req = mq2; cur_mem_addr = ma2;
    cur_valid = v2; cur_data = d2; cur_err = e2;
    case (sel)
      0: begin
        cur_ready = r0; cur_mem_req = mq0; cur_mem_addr = {32'h0, ma0};
        cur_valid = v0; cur_data = {32'h0, d0}; cur_err = e0;
      end
      1: begin
        cur_ready = r1; cur_mem_req = mq1; cur_mem_addr = {32'h0, ma1};
        cur_valid = v1; cur_data = {32'h0, d1}; cur_err = e1;
      end
      default: ;
    endcase
  end

  typedef struct {
    int          sel;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_beats;
    logic [63:0] exp_a0;
    logic [63:0] exp_a1;
    int          exp_lat;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one load and plays a bus that grants after gdly waiting cycles and
  // returns data the cycle after each grant; holds i_ready low rdly cycles.
  task automatic run_txn(input int s, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] rd0, input logic [63:0] rd1,
                         input int gdly, input int rdly,
                         output logic [63:0] data, output logic err, output int beats,
                         output logic [63:0] ad0, output logic [63:0] ad1,
                         output int lat, output bit stable, output bit back_idle);
    int          wait_cnt;
    bit          rsp_pend;
    bit          have_held;
    logic [63:0] held_addr;
    beats = 0; ad0 = '0; ad1 = '0; lat = 0; stable = 1'b1; back_idle = 1'b0;
    data = '0; err = 1'b0;
    wait_cnt = 0; rsp_pend = 1'b0; have_held = 1'b0; held_addr = '0;
    sel = s;
    i_funct3 = f3;
    i_addr   = a;
    i_valid0 = (s == 0);
    i_valid1 = (s == 1);
    i_valid2 = (s == 2);
    for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
      step();
      i_valid0 = 1'b0; i_valid1 = 1'b0; i_valid2 = 1'b0;
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
      if (cur_valid) begin
        lat = cyc;
      end else if (rsp_pend) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = (beats == 1) ? rd0 : rd1;
        rsp_pend     = 1'b0;
      end else if (cur_mem_req) begin
        if (have_held && cur_mem_addr != held_addr) stable = 1'b0;
        held_addr = cur_mem_addr;
        have_held = 1'b1;
        if (wait_cnt < gdly) begin
          wait_cnt++;
        end else begin
          i_mem_gnt = 1'b1;
          beats++;
          if (beats == 1) ad0 = cur_mem_addr;
          else ad1 = cur_mem_addr;
          rsp_pend  = 1'b1;
          have_held = 1'b0;
          wait_cnt  = 0;
        end
      end
    end
    data = cur_data;
    err  = cur_err;
    for (int k = 0; k < rdly; k++) begin
      step();
      if (!cur_valid || cur_data != data || cur_err != err || cur_ready) stable = 1'b0;
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    back_idle = !cur_valid && cur_ready;
    $display("txn sel=%0d f3=%0d addr=0x%0h data=0x%0h err=%0b beats=%0d lat=%0d",
             s, f3, a, data, err, beats, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] data, ad0, ad1;
    logic        err;
    int          beats, lat;
    bit          stable, back_idle, quiet;

    //            sel f3      addr                 rd0                   rd1                   exp_data              err beats a0                   a1            lat
    vecs[0]  = '{0, 3'b000, 64'h103,             64'h80FF_1234,        64'h0,                64'hFFFF_FF80,        1'b0, 1, 64'h100,            64'h0,        3};
    vecs[1]  = '{0, 3'b101, 64'h0FF,             64'hAB00_0000,        64'h0000_00CD,        64'h0000_CDAB,        1'b0, 2, 64'h0FC,            64'h100,      5};
    vecs[2]  = '{0, 3'b010, 64'h200,             64'h8765_4321,        64'h0,                64'h8765_4321,        1'b0, 1, 64'h200,            64'h0,        3};
    vecs[3]  = '{0, 3'b001, 64'h202,             64'h8765_4321,        64'h0,                64'hFFFF_8765,        1'b0, 1, 64'h200,            64'h0,        3};
    vecs[4]  = '{0, 3'b100, 64'h203,             64'h8765_4321,        64'h0,                64'h0000_0087,        1'b0, 1, 64'h200,            64'h0,        3};
    vecs[5]  = '{0, 3'b010, 64'h0FE,             64'hBBAA_0000,        64'h0000_DDCC,        64'hDDCC_BBAA,        1'b0, 2, 64'h0FC,            64'h100,      5};
    vecs[6]  = '{0, 3'b111, 64'h0,               64'h0,                64'h0,                64'h0,                1'b1, 0, 64'h0,              64'h0,        1};
    vecs[7]  = '{0, 3'b010, 64'hFFFF_FFFE,       64'h5566_0000,        64'h0000_8877,        64'h8877_5566,        1'b0, 2, 64'hFFFF_FFFC,      64'h0,        5};
    vecs[8]  = '{1, 3'b010, 64'h002,             64'h0,                64'h0,                64'h0,                1'b1, 0, 64'h0,              64'h0,        1};
    vecs[9]  = '{1, 3'b011, 64'h000,             64'h0,                64'h0,                64'h0,                1'b1, 0, 64'h0,              64'h0,        1};
    vecs[10] = '{1, 3'b001, 64'h002,             64'h1234_5678,        64'h0,                64'h0000_1234,        1'b0, 1, 64'h000,            64'h0,        3};
    vecs[11] = '{1, 3'b110, 64'h000,             64'h0,                64'h0,                64'h0,                1'b1, 0, 64'h0,              64'h0,        1};
    vecs[12] = '{2, 3'b110, 64'h00C,             64'hFEDC_BA98_7654_3210, 64'h0,             64'h0000_0000_FEDC_BA98, 1'b0, 1, 64'h008,         64'h0,        3};
    vecs[13] = '{2, 3'b011, 64'h008,             64'hFEDC_BA98_7654_3210, 64'h0,             64'hFEDC_BA98_7654_3210, 1'b0, 1, 64'h008,         64'h0,        3};
    vecs[14] = '{2, 3'b010, 64'h00C,             64'hFEDC_BA98_7654_3210, 64'h0,             64'hFFFF_FFFF_FEDC_BA98, 1'b0, 1, 64'h008,         64'h0,        3};
    vecs[15] = '{2, 3'b011, 64'h00C,             64'hFEDC_BA98_7654_3210, 64'h1122_3344_5566_7788, 64'h5566_7788_FEDC_BA98, 1'b0, 2, 64'h008, 64'h010, 5};
    vecs[16] = '{2, 3'b111, 64'h010,             64'h0,                64'h0,                64'h0,                1'b1, 0, 64'h0,              64'h0,        1};

    rst = 1'b1; sel = 0;
    i_valid0 = 1'b0; i_valid1 = 1'b0; i_valid2 = 1'b0;
    i_funct3 = '0; i_addr = '0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = '0; i_ready = 1'b0;
    repeat (3) step();

    // Reset state, observed while rst is still high
    for (int s = 0; s < 3; s += 2) begin
      sel = s;
      #1;
      check("rst_ready",    64'(cur_ready),   64'h1);
      check("rst_mem_req",  64'(cur_mem_req), 64'h0);
      check("rst_mem_addr", cur_mem_addr,     64'h0);
      check("rst_valid",    64'(cur_valid),   64'h0);
      check("rst_err",      64'(cur_err),     64'h0);
      check("rst_data",     cur_data,         64'h0);
    end
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_txn(vecs[i].sel, vecs[i].f3, vecs[i].addr, vecs[i].rd0, vecs[i].rd1, 0, 0,
              data, err, beats, ad0, ad1, lat, stable, back_idle);
      check($sformatf("v%0d_data", i),  data,           vecs[i].exp_data);
      check($sformatf("v%0d_err", i),   64'(err),       64'(vecs[i].exp_err));
      check($sformatf("v%0d_beats", i), 64'(beats),     64'(vecs[i].exp_beats));
      check($sformatf("v%0d_addr0", i), ad0,            vecs[i].exp_a0);
      check($sformatf("v%0d_addr1", i), ad1,            vecs[i].exp_a1);
      check($sformatf("v%0d_lat", i),   64'(lat),       64'(vecs[i].exp_lat));
      check($sformatf("v%0d_idle", i),  64'(back_idle), 64'h1);
    end

    // Grant held off 3 cycles and result held 4 cycles by the consumer
    run_txn(0, 3'b000, 64'h103, 64'h80FF_1234, 64'h0, 3, 4,
            data, err, beats, ad0, ad1, lat, stable, back_idle);
    check("stall_data",   data,             64'hFFFF_FF80);
    check("stall_stable", 64'(stable),      64'h1);
    check("stall_lat",    64'(lat),         64'h6);
    check("stall_addr",   ad0,              64'h100);
    check("stall_idle",   64'(back_idle),   64'h1);

    // Grant and rvalid together in REQ0: rvalid must not count
    sel = 0; i_funct3 = 3'b010; i_addr = 64'h300; i_valid0 = 1'b1;
    step();
    i_valid0 = 1'b0;
    i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 64'hDEAD_BEEF;
    step();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    step();
    check("same_cyc_wait", 64'(cur_valid), 64'h0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'h1234_5678;
    step();
    i_mem_rvalid = 1'b0;
    check("same_cyc_valid", 64'(cur_valid), 64'h1);
    check("same_cyc_data",  cur_data,       64'h1234_5678);
    $display("txn sel=0 f3=2 addr=0x300 data=0x%0h (gnt+rvalid same cycle)", cur_data);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;

    // Reset while waiting in RSP1, then a stray rvalid and grant
    sel = 0; i_funct3 = 3'b101; i_addr = 64'h0FF; i_valid0 = 1'b1;
    step();
    i_valid0 = 1'b0;
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 64'hAB00_0000;
    step();
    i_mem_rvalid = 1'b0;
    check("rst1_req1",  64'(cur_mem_req), 64'h1);
    check("rst1_addr1", cur_mem_addr,     64'h100);
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst1_ready", 64'(cur_ready),   64'h1);
    check("rst1_req",   64'(cur_mem_req), 64'h0);
    check("rst1_valid", 64'(cur_valid),   64'h0);
    i_mem_rvalid = 1'b1; i_mem_gnt = 1'b1; i_mem_rdata = 64'h0000_00CD;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      i_mem_rvalid = 1'b0; i_mem_gnt = 1'b0;
      if (cur_valid || cur_mem_req || !cur_ready) quiet = 1'b0;
    end
    check("rst1_quiet", 64'(quiet), 64'h1);
    $display("txn sel=0 f3=5 addr=0xff abandoned by reset in RSP1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
